// File: rtl/mill_rx_ctrl.sv
// -----------------------------------------------------------------------------
// mill_rx_ctrl
//
// Frame-level receive controller for a modified-Miller downlink. It arms the
// Miller demodulator, takes the decoded NRZ-L bit stream, detects start of
// frame, assembles 8-bit bytes (LSB first) with an odd-parity bit, and detects
// end of frame by an idle timeout after the last decoded bit.
//
// Parameters
//   TIMEOUT_CLKS   idle clocks after the last decoded bit that end the frame
//   MAX_BYTES      maximum data bytes per frame
//
// Ports
//   clk            847.5 kHz (fc/16) clock, the only clock
//   rst_n          synchronous active-low reset
//   in_start       one-cycle request to arm reception (honoured in IDLE only)
//   in_abort       one-cycle request to cancel reception
//   in_bit_valid   one-cycle strobe for in_bit
//   in_bit         decoded NRZ-L bit
//   out_dem_enable demodulator enable (high in WAIT_SOF and DATA)
//   out_byte       received byte, LSB first on air
//   out_byte_valid one-cycle strobe qualifying out_byte / out_nbits
//   out_nbits      valid bits in out_byte (8, or 7 for a short frame)
//   out_parity_err sticky per-frame odd-parity failure
//   out_frame_done one-cycle end-of-frame strobe
//   out_frame_err  framing error, valid with out_frame_done
//   out_byte_cnt   bytes emitted in the current frame
//   out_busy       high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module mill_rx_ctrl #(
    parameter int TIMEOUT_CLKS = 32,
    parameter int MAX_BYTES    = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_start,
    input  logic       in_abort,
    input  logic       in_bit_valid,
    input  logic       in_bit,
    output logic       out_dem_enable,
    output logic [7:0] out_byte,
    output logic       out_byte_valid,
    output logic [3:0] out_nbits,
    output logic       out_parity_err,
    output logic       out_frame_done,
    output logic       out_frame_err,
    output logic [6:0] out_byte_cnt,
    output logic       out_busy
);

    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        DATA     = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    k_q, k_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [6:0]    byte_cnt_q, byte_cnt_d;
    logic          parity_err_q, parity_err_d;
    logic [7:0]    byte_q, byte_d;
    logic [3:0]    nbits_q, nbits_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_err_q, frame_err_d;
    logic          dem_enable_q, dem_enable_d;
    logic          parity_ok;

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        shreg_d      = shreg_q;
        tmo_d        = tmo_q;
        byte_cnt_d   = byte_cnt_q;
        parity_err_d = parity_err_q;
        byte_d       = byte_q;
        nbits_d      = nbits_q;
        byte_valid_d = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = frame_err_q;
        // The parity bit is never stored: it is checked as it arrives.
        parity_ok    = ^{in_bit, shreg_q};

        unique case (state_q)
            IDLE: begin
                if (in_start) begin
                    state_d      = WAIT_SOF;
                    k_d          = 4'd0;
                    shreg_d      = 8'd0;
                    tmo_d        = '0;
                    byte_cnt_d   = 7'd0;
                    parity_err_d = 1'b0;
                    frame_err_d  = 1'b0;
                end
            end

            WAIT_SOF: begin
                if (in_abort) begin
                    state_d = IDLE;
                end else if (in_bit_valid) begin
                    if (in_bit) begin
                        state_d = DATA;
                        tmo_d   = '0;
                    end else begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                        frame_err_d  = 1'b1;
                    end
                end
            end

            DATA: begin
                if (in_abort) begin
                    state_d = IDLE;
                end else if (in_bit_valid) begin
                    // A bit always wins over a timeout expiring in the same cycle.
                    tmo_d = '0;
                    if (k_q == 4'd8) begin
                        k_d = 4'd0;
                        if (byte_cnt_q == 7'(MAX_BYTES)) begin
                            state_d      = DONE;
                            frame_done_d = 1'b1;
                            frame_err_d  = 1'b1;
                        end else begin
                            byte_d       = shreg_q;
                            nbits_d      = 4'd8;
                            byte_valid_d = 1'b1;
                            byte_cnt_d   = byte_cnt_q + 7'd1;
                            if (!parity_ok) begin
                                parity_err_d = 1'b1;
                            end
                        end
                    end else begin
                        for (int i = 0; i < 8; i++) begin
                            if (k_q == 4'(i)) begin
                                shreg_d[i] = in_bit;
                            end
                        end
                        k_d = k_q + 4'd1;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CLKS - 1)) begin
                    // End of frame: classify by how far into the slot we got.
                    tmo_d        = '0;
                    state_d      = DONE;
                    frame_done_d = 1'b1;
                    if (k_q == 4'd1 && !shreg_q[0]) begin
                        // Lone trailing 0 is the EOF marker.
                        frame_err_d = 1'b0;
                    end else if (k_q == 4'd8 && byte_cnt_q == 7'd0 && !shreg_q[7]) begin
                        // Short frame: 7 data bits followed by the EOF 0.
                        byte_d       = {1'b0, shreg_q[6:0]};
                        nbits_d      = 4'd7;
                        byte_valid_d = 1'b1;
                        byte_cnt_d   = 7'd1;
                        frame_err_d  = 1'b0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        dem_enable_d = (state_d == WAIT_SOF) || (state_d == DATA);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            k_q          <= 4'd0;
            shreg_q      <= 8'd0;
            tmo_q        <= '0;
            byte_cnt_q   <= 7'd0;
            parity_err_q <= 1'b0;
            byte_q       <= 8'd0;
            nbits_q      <= 4'd0;
            byte_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            dem_enable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            shreg_q      <= shreg_d;
            tmo_q        <= tmo_d;
            byte_cnt_q   <= byte_cnt_d;
            parity_err_q <= parity_err_d;
            byte_q       <= byte_d;
            nbits_q      <= nbits_d;
            byte_valid_q <= byte_valid_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            dem_enable_q <= dem_enable_d;
        end
    end

    assign out_dem_enable = dem_enable_q;
    assign out_byte       = byte_q;
    assign out_byte_valid = byte_valid_q;
    assign out_nbits      = nbits_q;
    assign out_parity_err = parity_err_q;
    assign out_frame_done = frame_done_q;
    assign out_frame_err  = frame_err_q;
    assign out_byte_cnt   = byte_cnt_q;
    assign out_busy       = (state_q != IDLE);

endmodule
